// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo. The master side drives requests
// and write data; the slave side is the FIFO.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  wr;
  logic                  rd;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;

  modport master (output wr, rd, data_in, input data_out, full, empty, count);
  modport slave  (input wr, rd, data_in, output data_out, full, empty, count);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: register-array storage, binary pointers with an extra wrap bit,
// registered read data. DEPTH must be a power of two and at least 2, and must match
// the connected interface instance.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sync_fifo_if.slave   bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  full, empty, wr_acc, rd_acc;

  // Flags decode registered pointers only, so accepts use pre-edge status.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                  (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign wr_acc = bus.wr && !full;
  assign rd_acc = bus.rd && !empty;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = wr_ptr - rd_ptr;
  assign bus.data_out = dout_q;

  // Storage is intentionally not reset; reads from it are gated by empty.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed stimulus for sync_fifo, checked every cycle against a
// queue-based model plus literal expectations for the directed scenarios.
module tb_sync_fifo;
  localparam int DW = 8;
  localparam int DP = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model: occupancy is the queue size, output is the last popped word.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout = '0;
  bit            cmp_en = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_dout = '0;
    end else begin
      automatic bit do_rd = bus.rd && (q.size() != 0);
      automatic bit do_wr = bus.wr && (q.size() != DP);
      if (do_rd) m_dout = q.pop_front();
      if (do_wr) q.push_back(bus.data_in);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_count", 32'(bus.count), 32'(q.size()));
      check("model_full",  32'(bus.full),  32'(q.size() == DP));
      check("model_empty", 32'(bus.empty), 32'(q.size() == 0));
      check("model_dout",  32'(bus.data_out), 32'(m_dout));
    end
  end

  // Apply inputs for exactly one rising edge; returns 2 ns after that edge.
  task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
    bus.wr = w; bus.rd = r; bus.data_in = d;
    @(posedge clk); #2;
    bus.wr = 1'b0; bus.rd = 1'b0;
  endtask

  logic [DW-1:0] fill [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd155, 8'd218, 8'd60};

  initial begin
    bus.wr = 1'b0; bus.rd = 1'b0; bus.data_in = '0;
    #11;
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_dout",  32'(bus.data_out), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;

    // Fill to full
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, fill[i]);
      check("fill_count", 32'(bus.count), 32'(i + 1));
    end
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_empty", 32'(bus.empty), 32'd0);

    // Overflow write is dropped
    drive(1'b1, 1'b0, 8'hAA);
    check("ovf_count", 32'(bus.count), 32'd8);

    // Drain plus two reads past empty
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, '0);
      check("drain_dout", 32'(bus.data_out), 32'(fill[(i < 8) ? i : 7]));
      if (i == 7) check("drain_empty", 32'(bus.empty), 32'd1);
    end
    check("udf_count", 32'(bus.count), 32'd0);
    check("udf_dout",  32'(bus.data_out), 32'd60);

    // Simultaneous at empty: write only
    drive(1'b1, 1'b1, 8'h21);
    check("sim_empty_count", 32'(bus.count), 32'd1);
    check("sim_empty_dout",  32'(bus.data_out), 32'd60);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'h22 + i));
    check("hold4_start", 32'(bus.count), 32'd4);

    // Steady state at 4 across wraps; first popped word is 0x21
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 8'($urandom));
      check("hold4_count", 32'(bus.count), 32'd4);
      if (i == 0) check("hold4_first", 32'(bus.data_out), 32'h21);
    end

    // Simultaneous at full: read only
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'($urandom));
    check("full_again", 32'(bus.full), 32'd1);
    drive(1'b1, 1'b1, 8'h77);
    check("sim_full_count", 32'(bus.count), 32'd7);

    // Random traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    // Set up count=5 with non-zero data_out, then reset between edges
    while (bus.empty !== 1'b1 && vectors < 100000) drive(1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(8'h11 + i));
    drive(1'b0, 1'b1, '0);
    check("pre_rst_count", 32'(bus.count), 32'd5);
    check("pre_rst_dout",  32'(bus.data_out), 32'h11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_dout",  32'(bus.data_out), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    drive(1'b1, 1'b0, 8'h5A);
    drive(1'b0, 1'b1, '0);
    check("post_rst_dout",  32'(bus.data_out), 32'h5A);
    check("post_rst_empty", 32'(bus.empty), 32'd1);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock first-in/first-out buffer with a write port, a read port and full/empty status. It decouples a producer and a consumer in the same clock domain. Storage is a register array of DEPTH words, addressed by binary read/write pointers that carry one extra wrap bit. Read data is registered.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out in bits.
DEPTH, 8, number of storage words; must be a power of two and at least 2.
ADDR_WIDTH, log2(DEPTH) = 3, pointer index width (derived; not to be overridden independently).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
wr  input  1  write request; data_in is captured when accepted.
rd  input  1  read request; head word is popped to data_out when accepted.
data_in  input  DATA_WIDTH  write data.
data_out  output  DATA_WIDTH  registered read data.
full  output  1  high when DEPTH words are stored.
empty  output  1  high when 0 words are stored.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: wr_ptr=0, rd_ptr=0, data_out=0, empty=1, full=0, count=0. Storage contents are not cleared and are don't-care.
- Pointers are ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits index storage. The MSB toggles on each wrap.
- empty = (wr_ptr == rd_ptr).
- full = (index bits equal) AND (MSBs differ).
- count = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- full, empty and count are combinational decodes of registered pointers only. They change only after a clock edge or reset, never as a direct function of wr/rd.
- Write accept: wr=1 AND full=0, using pre-edge flag values. On the edge: mem[wr_ptr index] <= data_in; wr_ptr increments.
- Read accept: rd=1 AND empty=0, using pre-edge flag values. On the edge: data_out <= mem[rd_ptr index]; rd_ptr increments. Latency is one clock from an accepted read to valid data_out.
- data_out holds its last value whenever no read is accepted, including reads while empty.
- Write while full is ignored: no storage or pointer change, no error flag.
- Read while empty is ignored: pointers and data_out are unchanged.
- Simultaneous wr and rd:
  - neither full nor empty: both are accepted, count is unchanged.
  - full: only the read is accepted, so count drops by 1.
  - empty: only the write is accepted, so count rises by 1 (no fall-through).
- Wrap-around: index bits roll from DEPTH-1 to 0 and the MSB toggles. Ordering is preserved across any number of wraps.
- Reset asserted mid-operation immediately empties the FIFO and zeroes data_out regardless of clk. Data written before reset is never read out afterwards.
- No X propagation from unwritten storage to data_out is permitted, because reads from empty are blocked.

Test Plan:
- Reset: hold rst_n=0 for 10 ns, then release -> empty=1, full=0, count=0, data_out=0.
- Fill: wr=1 for 8 consecutive cycles with data 1,2,3,4,5,155,218,60 -> count steps 1..8; full=1 and empty=0 after the 8th edge.
- Drain: wr=0, rd=1 for 10 cycles -> data_out = 1,2,3,4,5,155,218,60 on successive edges. empty=1 after the 8th read. Extra reads keep data_out=60 and count=0.
- Overflow and underflow:
  - Write 9th word 0xAA while full -> ignored; subsequent drain returns only the original 8.
  - rd while empty -> pointers unchanged.
- Simultaneous access and wrap:
  - Hold count=4 and pulse wr=rd=1 for 20 cycles -> count stays 4; output order equals input order across pointer wraps.
  - At full, wr=rd=1 -> count becomes 7.
  - At empty, wr=rd=1 -> count becomes 1.
- Mid-operation reset: with count=5, assert rst_n=0 between clock edges -> empty=1, count=0 and data_out=0 immediately. After release, the first write/read returns the new data only.
